// File: rtl/mac_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_ctrl_pkg : shared types and constants for the mac sequencing control   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package mac_ctrl_pkg;

    localparam int c_DEF_LEN_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

    // Counter must be able to hold N_ROWS-1 with headroom for the terminal compare.
    function automatic int drain_cnt_w(input int n_rows);
        return $clog2(n_rows + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_skew_line.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_skew_line : per-row delay line for the (vld, init) strobe pair          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mac_skew_line #(
    parameter int N_ROWS = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_vld,
    input  logic              i_init,
    output logic [N_ROWS-1:0] o_vld,
    output logic [N_ROWS-1:0] o_init
);

    // Row 0 is the live strobe; row r is row r-1 delayed by one register.
    assign o_vld[0]  = i_vld;
    assign o_init[0] = i_init;

    generate
        if (N_ROWS > 1) begin : g_stages
            logic [N_ROWS-2:0] r_vld;
            logic [N_ROWS-2:0] r_init;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_vld  <= '0;
                    r_init <= '0;
                end else begin
                    r_vld  <= o_vld[N_ROWS-2:0];
                    r_init <= o_init[N_ROWS-2:0];
                end
            end

            assign o_vld[N_ROWS-1:1]  = r_vld;
            assign o_init[N_ROWS-1:1] = r_init;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_seq_ctrl : job sequencer driving skewed strobes into a chain of macs   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mac_seq_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int N_ROWS = 4,
    parameter int LEN_W  = c_DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              len_err,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [N_ROWS-1:0] mac_src_vld,
    output logic [N_ROWS-1:0] mac_init,
    output logic [N_ROWS-1:0] mac_clear,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              done
);

    localparam int                 c_DRN_W    = drain_cnt_w(N_ROWS);
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(N_ROWS - 1);

    state_e             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic [c_DRN_W-1:0] r_drn;
    logic               w_accept;
    logic               w_init0;

    assign w_accept  = (r_state == RUN) && in_vld;
    assign w_init0   = w_accept && (r_cnt == '0);
    assign w_cnt_inc = r_cnt + LEN_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_drn   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        r_state <= RUN;
                        r_len   <= len;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_len) begin
                            r_state <= DRAIN;
                            r_drn   <= '0;
                        end
                    end
                end
                // N_ROWS cycles let the last row's final accumulate land.
                DRAIN: begin
                    if (r_drn == c_DRN_LAST) begin
                        r_state <= OUT;
                    end else begin
                        r_drn <= r_drn + c_DRN_W'(1);
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    mac_skew_line #(
        .N_ROWS (N_ROWS)
    ) u_skew (
        .clk    (clk),
        .rstn   (rstn),
        .i_vld  (w_accept),
        .i_init (w_init0),
        .o_vld  (mac_src_vld),
        .o_init (mac_init)
    );

    assign busy      = (r_state != IDLE);
    assign in_rdy    = (r_state == RUN);
    assign out_vld   = (r_state == OUT);
    assign done      = (r_state == OUT) && out_rdy;
    assign mac_clear = {N_ROWS{done}};
    assign len_err   = (r_state == IDLE) && start && (len == '0);

endmodule
`default_nettype wire

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencing controller for a chain of `mac` processing elements in the PE array. It accepts a dot-product job of programmable length and pulls operands from an upstream feeder with a valid/ready handshake. It generates per-row skewed `init`, `src_vld` and `clear` strobes that match the one-cycle-per-row `src_1` forwarding through the chain, then presents a result-valid handshake to the drain logic.

## Interface
- `N_ROWS`, default 4: number of chained mac rows, ≥1.
- `LEN_W`, default 10: width of the job-length field.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: job request, sampled in IDLE only.
- `len` in LEN_W: number of accumulate terms, sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `len_err` out 1: one-cycle pulse when `start` arrives with `len`==0.
- `in_vld` in 1: feeder has an operand pair this cycle.
- `in_rdy` out 1: controller accepts an operand (RUN state).
- `mac_src_vld` out N_ROWS: per-row accumulate strobe; bit r drives row r.
- `mac_init` out N_ROWS: per-row first-term strobe, so acc loads the product instead of adding it.
- `mac_clear` out N_ROWS: per-row synchronous accumulator clear.
- `out_vld` in/out: `out_vld` is an output, 1 bit: all row accumulators are final.
- `out_rdy` in 1: drain logic consumes results.
- `done` out 1: one-cycle pulse on the output handshake.

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - `start`=1 and `len`≠0: latch `len`, clear the term counter, go to RUN.
  - `start`=1 and `len`=0: pulse `len_err`, stay in IDLE.
- RUN:
  - `in_rdy`=1. A term is accepted when `in_vld`&&`in_rdy`.
  - Row-0 strobes are combinational. `mac_src_vld[0]` = accept. `mac_init[0]` = accept && counter==0.
  - Each accept increments the counter. The accept that makes the counter equal the latched `len` moves the FSM to DRAIN.
  - `in_vld`=0 stalls the job with no timeout, and the bubble propagates down the skew line.
- DRAIN:
  - Wait exactly N_ROWS cycles so that the last row's final accumulate has landed, then go to OUT.
- OUT:
  - `out_vld`=1 until `out_rdy`.
  - On the handshake, in the same cycle: `mac_clear` is all-ones, `done` pulses, and the FSM goes to IDLE.
- Skew line: for r≥1, `mac_src_vld[r]` and `mac_init[r]` equal row r-1's strobes registered one cycle. Row r therefore sees term k exactly r cycles after row 0. `mac_clear` is not skewed.
- `start` while `busy` is ignored. `len` changes after sampling have no effect.
- Term counter is LEN_W bits and never wraps, because the maximum `len` is 2^LEN_W−1.

## Timing
- Reset values (asynchronous, immediate): state IDLE, counter 0, skew line 0, and every output 0.
- Reset mid-job abandons the job and clears the skew line. The mac accumulators are not cleared by this block; the next job's `init` overwrites them.
- Latency: `start` in cycle 0 → RUN from cycle 1. With no stalls, the last accept is in cycle `len` and DRAIN runs in cycles `len`+1 … `len`+N_ROWS. `out_vld` rises in cycle `len`+N_ROWS+1.
- `in_rdy` drops in the cycle after the final accept; there are no over-accepts.
- `out_vld` holds indefinitely under `out_rdy` back-pressure, and the accumulators are stable during that time.
- The earliest next `start` is accepted in the cycle after the output handshake.

## Structure
- Package `mac_ctrl_pkg` holds:
  - the state enum (`IDLE`, `RUN`, `DRAIN`, `OUT`);
  - the default `LEN_W`;
  - the DRAIN counter width function, clog2(N_ROWS+1).
- Sub-module `mac_skew_line`: a parameterised N_ROWS-deep, 2-bit-wide (`vld`, `init`) shift register with asynchronous reset. It has one tap per row.
- The top level contains the FSM, term counter, drain counter and output decode.

## Test plan
- N_ROWS=4, `len`=3, `in_vld` held at 1, `start` in cycle 0:
  - `mac_src_vld[0]` high in cycles 1–3, with `mac_init[0]` in cycle 1;
  - `mac_src_vld[3]` high in cycles 4–6, with `mac_init[3]` in cycle 4;
  - `out_vld` rises in cycle 8.
- Same job with `in_vld` low in cycle 2:
  - row-0 strobes in cycles 1, 3, 4;
  - row-3 strobes in cycles 4, 6, 7;
  - `out_vld` rises in cycle 9.
- `out_rdy` held low for 5 cycles after `out_vld`, then raised:
  - `out_vld` stays high throughout;
  - `mac_clear`=4'hF and `done` for exactly one cycle;
  - `busy`=0 in the next cycle.
- `start` with `len`=0:
  - `len_err` pulses for one cycle;
  - the FSM stays in IDLE and no strobes are issued.
- `start` pulsed during RUN and during OUT: ignored, and the job completes with unchanged timing.
- `rstn` asserted in cycle 2 of a `len`=5 job:
  - all outputs are 0 immediately and the skew line is empty;
  - a new `start` after release produces a clean job with `mac_init[0]` on its first accept.
